// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, halt encoding, PC reset
// vector and the fetch-stage state encoding.
package mips_pkg;

  localparam int unsigned BITS_SIZE_DEF = 32;

  localparam logic [BITS_SIZE_DEF-1:0] HALT_WORD    = 32'hFFFF_FFFF;
  localparam logic [BITS_SIZE_DEF-1:0] PC_RESET_VEC = 32'h0000_0000;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: combinational read, write on the clock edge.
// Byte addresses wrap modulo MEM_DEPTH*4 and their low two bits are ignored.
module instruction_memory
  import mips_pkg::*;
#(
  parameter int unsigned BITS_SIZE = BITS_SIZE_DEF,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic                 i_clk,
  input  logic                 i_wr_en,
  input  logic [BITS_SIZE-1:0] i_wr_addr,
  input  logic [BITS_SIZE-1:0] i_wr_data,
  input  logic [BITS_SIZE-1:0] i_rd_addr,
  output logic [BITS_SIZE-1:0] o_rd_data
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic [BITS_SIZE-1:0] mem [MEM_DEPTH];
  logic [AW-1:0]        wr_idx;
  logic [AW-1:0]        rd_idx;

  assign wr_idx = i_wr_addr[AW+1:2];
  assign rd_idx = i_rd_addr[AW+1:2];

  // No reset on the array: program contents survive a pipeline reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = mem[rd_idx];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_wr_addr[BITS_SIZE-1:AW+2], i_wr_addr[1:0],
                              i_rd_addr[BITS_SIZE-1:AW+2], i_rd_addr[1:0]};

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, next-PC select and instruction memory.
// Halt detection and the HALTED state exist only when IF_HALT_DETECT_EN is defined.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int unsigned          BITS_SIZE   = BITS_SIZE_DEF,
  parameter int unsigned          MEM_DEPTH   = 256,
  parameter logic [BITS_SIZE-1:0] HALT_OPCODE = HALT_WORD
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_pc_write,
  input  logic                 i_branch_taken,
  input  logic [BITS_SIZE-1:0] i_branch_target,
  input  logic                 i_jump,
  input  logic [BITS_SIZE-1:0] i_jump_target,
  input  logic                 i_mem_wr_en,
  input  logic [BITS_SIZE-1:0] i_mem_wr_addr,
  input  logic [BITS_SIZE-1:0] i_mem_wr_data,
  output logic [BITS_SIZE-1:0] o_pc,
  output logic [BITS_SIZE-1:0] o_pc4,
  output logic [BITS_SIZE-1:0] o_pc8,
  output logic [BITS_SIZE-1:0] o_instruction,
  output logic                 o_halt
);

  localparam logic [BITS_SIZE-1:0] PC_INC4 = BITS_SIZE'(4);
  localparam logic [BITS_SIZE-1:0] PC_INC8 = BITS_SIZE'(8);

  logic [BITS_SIZE-1:0] pc_q, pc_d;
  logic [BITS_SIZE-1:0] instr;
  logic                 adv;
  logic                 halt_hit;

  instruction_memory #(
    .BITS_SIZE (BITS_SIZE),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_imem (
    .i_clk     (i_clk),
    .i_wr_en   (i_mem_wr_en),
    .i_wr_addr (i_mem_wr_addr),
    .i_wr_data (i_mem_wr_data),
    .i_rd_addr (pc_q),
    .o_rd_data (instr)
  );

`ifdef IF_HALT_DETECT_EN
  fetch_state_e state_q, state_d;

  assign adv      = i_step & i_pc_write & (state_q == FETCH_RUN);
  assign halt_hit = (instr == HALT_OPCODE);
  assign o_halt   = (state_q == FETCH_HALTED);

  always_comb begin
    state_d = state_q;
    if (adv && halt_hit) begin
      state_d = FETCH_HALTED;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= FETCH_RUN;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign adv      = i_step & i_pc_write;
  assign halt_hit = 1'b0;
  assign o_halt   = 1'b0;

  logic unused_halt_opcode;
  assign unused_halt_opcode = ^HALT_OPCODE;
`endif

  // Halt freezes the PC on the halting edge so IF/ID keeps seeing the halt word.
  always_comb begin
    pc_d = pc_q;
    if (adv) begin
      if (halt_hit) begin
        pc_d = pc_q;
      end else if (i_jump) begin
        pc_d = i_jump_target;
      end else if (i_branch_taken) begin
        pc_d = i_branch_target;
      end else begin
        pc_d = pc_q + PC_INC4;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q <= PC_RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_pc4         = pc_q + PC_INC4;
  assign o_pc8         = pc_q + PC_INC8;
  assign o_instruction = instr;

endmodule
